// File: rtl/cordic_vectoring.sv
// cordic_vectoring
//   Iterative CORDIC in vectoring mode. Converts a packed Cartesian pair
//   (x, y) into a packed magnitude and binary phase angle, one
//   micro-rotation per clock. Uses the same en/busy/data_w/data_r
//   handshake as the rotation-mode datapath.
//
//   Angle format: 2^(B-1) LSB = pi. The result wraps modulo 2^B.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   en      in   start request, sampled only while idle
//   data_w  in   {x[2B-1:B], y[B-1:0]}, signed two's complement
//   busy    out  high while a conversion is in progress
//   done    out  one-cycle pulse when data_r is updated
//   data_r  out  {mag[2B-1:B] unsigned, ang[B-1:0] signed}
//
// Optional build macro
//   CORDIC_VEC_GAIN_COMP_EN  adds a SCALE state that multiplies the
//                            magnitude by ~1/K (0.60725) before output.
//
// state   | meaning
// S_IDLE  | waiting for en; loads and pre-rotates the input
// S_ITER  | one micro-rotation per cycle, i = 0..N-1
// S_SCALE | gain compensation of x (only with the macro defined)
// S_OUT   | saturate magnitude, register data_r, pulse done
module cordic_vectoring #(
  parameter int B = 14,
  parameter int N = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2*B-1:0] data_w,
  output logic           busy,
  output logic           done,
  output logic [2*B-1:0] data_r
);

  // x/y carry two guard bits: gain ~1.647 * sqrt2, and -(-2^(B-1)).
  localparam int XW = B + 2;
  localparam int ZW = B + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [ZW-1:0] Z_QTR = ZW'(2 ** (B - 2));
  localparam logic [B-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_OUT} state_t;

  // atan(2^-i)/pi scaled to 2^31.
  function automatic logic [31:0] atan_raw(input int idx);
    case (idx)
      0:       atan_raw = 32'h2000_0000;
      1:       atan_raw = 32'h12E4_051E;
      2:       atan_raw = 32'h09FB_385B;
      3:       atan_raw = 32'h0511_11D4;
      4:       atan_raw = 32'h028B_0D43;
      5:       atan_raw = 32'h0145_D7E1;
      6:       atan_raw = 32'h00A2_F61E;
      7:       atan_raw = 32'h0051_7C55;
      8:       atan_raw = 32'h0028_BE53;
      9:       atan_raw = 32'h0014_5F2F;
      10:      atan_raw = 32'h000A_2F98;
      11:      atan_raw = 32'h0005_17CC;
      12:      atan_raw = 32'h0002_8BE6;
      13:      atan_raw = 32'h0001_45F3;
      14:      atan_raw = 32'h0000_A2F9;
      15:      atan_raw = 32'h0000_517C;
      default: atan_raw = 32'h0000_0000;
    endcase
  endfunction

  // Round-to-nearest down to the B-bit angle scale.
  function automatic logic signed [ZW-1:0] atan_q(input int idx);
    logic [32:0] v;
    v = {1'b0, atan_raw(idx)} + (33'd1 << (31 - B));
    atan_q = ZW'(v >> (32 - B));
  endfunction

  state_t                 r_state;
  logic signed [XW-1:0]   r_x;
  logic signed [XW-1:0]   r_y;
  logic signed [ZW-1:0]   r_z;
  logic [IW-1:0]          r_i;
  logic                   r_zero;
  logic                   r_busy;
  logic                   r_done;
  logic [2*B-1:0]         r_data;

  logic signed [XW-1:0]   w_x_in, w_y_in, w_x0, w_y0;
  logic signed [XW-1:0]   w_x_sh, w_y_sh, w_x_nx, w_y_nx;
  logic signed [ZW-1:0]   w_z0, w_z_nx, w_atan;
  logic [B-1:0]           w_mag;

  assign w_x_in = {{2{data_w[2*B-1]}}, data_w[2*B-1:B]};
  assign w_y_in = {{2{data_w[B-1]}}, data_w[B-1:0]};
  assign w_x_sh = r_x >>> r_i;
  assign w_y_sh = r_y >>> r_i;
  assign w_atan = atan_q(int'(r_i));

  // Pre-rotation by +/-90 degrees folds the left half-plane onto the right.
  always_comb begin
    w_x0 = w_x_in;
    w_y0 = w_y_in;
    w_z0 = '0;
    if (w_x_in[XW-1]) begin
      if (!w_y_in[XW-1]) begin
        w_x0 = w_y_in;
        w_y0 = -w_x_in;
        w_z0 = Z_QTR;
      end else begin
        w_x0 = -w_y_in;
        w_y0 = w_x_in;
        w_z0 = -Z_QTR;
      end
    end
  end

  always_comb begin
    if (!r_y[XW-1]) begin
      w_x_nx = r_x + w_y_sh;
      w_y_nx = r_y - w_x_sh;
      w_z_nx = r_z + w_atan;
    end else begin
      w_x_nx = r_x - w_y_sh;
      w_y_nx = r_y + w_x_sh;
      w_z_nx = r_z - w_atan;
    end
  end

  // Positive x never exceeds 2^(B+1)-1, so bit B alone flags overflow.
  always_comb begin
    w_mag = r_x[B-1:0];
    if (r_x[XW-1])
      w_mag = '0;
    else if (r_x[B])
      w_mag = MAG_MAX;
  end

`ifdef CORDIC_VEC_GAIN_COMP_EN
  // x * (2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13), summed exactly then truncated.
  logic signed [XW+12:0] w_xe, w_prod;
  logic signed [XW-1:0]  w_scaled;
  assign w_xe     = {{13{r_x[XW-1]}}, r_x};
  assign w_prod   = (w_xe <<< 12) + (w_xe <<< 10) - (w_xe <<< 7) - (w_xe <<< 4) - w_xe;
  assign w_scaled = w_prod[XW+12:13];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_i     <= '0;
            r_zero  <= (data_w == '0);
            r_busy  <= 1'b1;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_x <= w_x_nx;
          r_y <= w_y_nx;
          r_z <= w_z_nx;
          if (r_i == IW'(N - 1)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
            r_state <= S_SCALE;
`else
            r_state <= S_OUT;
`endif
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
`ifdef CORDIC_VEC_GAIN_COMP_EN
        S_SCALE: begin
          r_x     <= w_scaled;
          r_state <= S_OUT;
        end
`endif
        S_OUT: begin
          r_data  <= r_zero ? '0 : {w_mag, r_z[B-1:0]};
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign data_r = r_data;

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;

  localparam int B = 14;
  localparam int N = 7;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int LAT  = N + 2;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = N + 1;
  localparam bit COMP = 1'b0;
`endif
  localparam real PI = 3.14159265358979;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic [2*B-1:0] data_w = '0;
  logic           busy;
  logic           done;
  logic [2*B-1:0] data_r;

  int  n_checks = 0;
  int  n_pass   = 0;
  real k_n;

  always #5 clk = ~clk;

  cordic_vectoring #(.B(B), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .data_w (data_w),
    .busy   (busy),
    .done   (done),
    .data_r (data_r)
  );

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    n_checks++;
    if (obs >= exp - tol && obs <= exp + tol)
      n_pass++;
    else
      $display("FAIL %s: got %0d, want %0d (+/-%0d) at %0t", tag, obs, exp, tol, $time);
  endtask

  function automatic logic [2*B-1:0] pack(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[B-1:0], yv[B-1:0]};
  endfunction

  // Reference: ideal polar conversion scaled by the CORDIC gain.
  task automatic check_result(input string tag, input int x, input int y,
                              input logic [2*B-1:0] res, input int mtol, input int atol);
    real rm, ra, e;
    int  m_obs, a_obs, m_exp, a_err;
    m_obs = int'(res[2*B-1:B]);
    a_obs = int'($signed(res[B-1:0]));
    if (x == 0 && y == 0) begin
      chk({tag, "_mag"}, m_obs, 0, 0);
      chk({tag, "_ang"}, a_obs, 0, 0);
    end else begin
      rm = $sqrt(real'(x * x + y * y)) * k_n;
      if (COMP) rm = rm * 4975.0 / 8192.0;
      if (rm >= 16383.0 + 2.0 * mtol) begin
        chk({tag, "_mag_sat"}, m_obs, 16383, 0);
      end else begin
        m_exp = $rtoi(rm + 0.5);
        if (m_exp > 16383) m_exp = 16383;
        chk({tag, "_mag"}, m_obs, m_exp, mtol);
      end
      ra = $atan2(real'(y), real'(x)) / PI * 8192.0;
      e  = real'(a_obs) - ra;
      while (e > 8192.0)  e = e - 16384.0;
      while (e < -8192.0) e = e + 16384.0;
      a_err = $rtoi(e + ((e >= 0.0) ? 0.5 : -0.5));
      chk({tag, "_ang_err"}, a_err, 0, atol);
    end
  endtask

  task automatic convert(input int x, input int y, output logic [2*B-1:0] res, output int lat);
    @(negedge clk);
    data_w = pack(x, y);
    en     = 1'b1;
    @(posedge clk); #1;
    en  = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = data_r;
  endtask

  task automatic run_case(input string tag, input int x, input int y, input int mtol, input int atol);
    logic [2*B-1:0] res;
    int             lat;
    convert(x, y, res, lat);
    chk({tag, "_latency"}, lat, LAT, 0);
    chk({tag, "_busy_end"}, int'(busy), 0, 0);
    check_result(tag, x, y, res, mtol, atol);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, int'(done), 0, 0);
  endtask

  initial begin
    int cyc, last, nres, lat, ndone, cx, cy;
    logic [2*B-1:0] res;

    k_n = 1.0;
    for (int i = 0; i < N; i++) k_n = k_n * $sqrt(1.0 + 1.0 / (4.0 ** i));

    #12;
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_data", int'(data_r), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_case("axis_x", 4096, 0, 8, 48);
    run_case("axis_y", 0, 4096, 8, 48);
    run_case("q3", -4096, -4096, 12, 48);
    run_case("full_q3", -8192, -8192, 12, 48);
    run_case("neg_x", -8192, 0, 12, 48);
    run_case("zero", 0, 0, 0, 0);

    // en pulsed on the 3rd busy cycle with new data must be ignored
    @(negedge clk);
    data_w = pack(3000, -2000);
    en     = 1'b1;
    @(posedge clk); #1;
    en  = 1'b0;
    lat = 0;
    chk("ign_busy_start", int'(busy), 1, 0);
    @(posedge clk); #1; lat++;
    @(posedge clk); #1; lat++;
    @(negedge clk);
    data_w = pack(-5000, 1234);
    en     = 1'b1;
    @(posedge clk); #1; lat++;
    en = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_latency", lat, LAT, 0);
    check_result("ign", 3000, -2000, data_r, 12, 48);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("ign_no_restart", int'(busy), 0, 0);
    end

    // en held high: back-to-back conversions, new data offered at each done
    cx = 5000; cy = 7000;
    @(negedge clk);
    data_w = pack(cx, cy);
    en     = 1'b1;
    @(posedge clk); #1;
    cyc = 0; last = 0; nres = 0;
    while (nres < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        check_result("b2b", cx, cy, data_r, 12, 48);
        chk("b2b_gap", cyc - last, (nres == 0) ? LAT : LAT + 1, 0);
        last = cyc;
        nres++;
        cx = int'($urandom_range(12000)) - 6000;
        cy = (nres == 1) ? -7000 : 6500;
        data_w = pack(cx, cy);
      end
    end
    en = 1'b0;
    chk("b2b_count", nres, 3, 0);
    @(posedge clk); #1;

    // async reset mid-ITER, between clock edges
    @(negedge clk);
    data_w = pack(-3000, 2500);
    en     = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0, 0);
    chk("arst_done", int'(done), 0, 0);
    chk("arst_data", int'(data_r), 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("arst_no_done", ndone, 0, 0);
    run_case("after_rst", -3000, 2500, 12, 48);

    // randomized vectors, kept away from the origin so the phase is meaningful
    for (int t = 0; t < 20; t++) begin
      int x, y;
      do begin
        x = int'($urandom_range(16383)) - 8192;
        y = int'($urandom_range(16383)) - 8192;
      end while (x > -2048 && x < 2048 && y > -2048 && y < 2048);
      run_case("rand", x, y, 12, 64);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
